audio_peak_meter: RTL

Stereo peak-level meter that consumes the 24-bit signed sample stream on the codec write path, after the noise/FIR output selector, on the same clock. It tracks per-channel absolute peak with hold-then-exponential-decay. It drives a log-scaled (6 dB/segment) thermometer bar per channel and a stretched clip flag, so the board LEDs show filtered vs. noisy signal level.

---
 rtl/audio_peak_meter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/audio_peak_meter.sv
// Stereo peak meter: per-channel |sample| peak with hold then exponential decay, 6 dB/segment bar, stretched clip.
// One-cycle registered latency on each valid sample; never stalls, every valid is consumed.
module audio_peak_meter #(
    parameter int             W            = 24,
    parameter int             SEGS         = 5,
    parameter int             HOLD_SAMPLES = 4800,
    parameter int             DECAY_SHIFT  = 6,
    parameter logic [W-1:0]   CLIP_THRESH  = 24'h7F0000,
    parameter int             CLIP_HOLD    = 24000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid,
    input  logic [W-1:0]        sample_left,
    input  logic [W-1:0]        sample_right,
    output logic [W-2:0]        peak_left,
    output logic [W-2:0]        peak_right,
    output logic [SEGS-1:0]     bar_left,
    output logic [SEGS-1:0]     bar_right,
    output logic                clip_left,
    output logic                clip_right
);

    localparam int HW_RAW   = $clog2(HOLD_SAMPLES + 1);
    localparam int CW_RAW   = $clog2(CLIP_HOLD + 1);
    localparam int HW       = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam int CW       = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int BAR_BASE = W - 1 - SEGS;

    logic [W-1:0]    smp        [2];
    logic [W-1:0]    neg        [2];
    logic [W-2:0]    mag        [2];
    logic [W-2:0]    dec        [2];
    logic [W-2:0]    decayed    [2];
    logic [W-2:0]    peak_q     [2];
    logic [W-2:0]    peak_d     [2];
    logic [HW-1:0]   hold_q     [2];
    logic [HW-1:0]   hold_d     [2];
    logic [CW-1:0]   clip_cnt_q [2];
    logic [CW-1:0]   clip_cnt_d [2];
    logic [SEGS-1:0] bar_q      [2];
    logic [SEGS-1:0] bar_d      [2];
    logic            clip_q     [2];
    logic            clip_d     [2];

    assign smp[0] = sample_left;
    assign smp[1] = sample_right;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            neg[c] = ~smp[c] + W'(1);
            // Negating the most-negative code overflows back to a negative value: saturate it.
            if (!smp[c][W-1])
                mag[c] = smp[c][W-2:0];
            else if (neg[c][W-1])
                mag[c] = '1;
            else
                mag[c] = neg[c][W-2:0];

            dec[c] = peak_q[c] >> DECAY_SHIFT;
            if (dec[c] == '0)
                dec[c] = (W-1)'(1);
            decayed[c] = (peak_q[c] >= dec[c]) ? (peak_q[c] - dec[c]) : '0;

            peak_d[c]     = peak_q[c];
            hold_d[c]     = hold_q[c];
            clip_cnt_d[c] = clip_cnt_q[c];
            clip_d[c]     = clip_q[c];

            if (valid) begin
                if (mag[c] > peak_q[c]) begin
                    peak_d[c] = mag[c];
                    hold_d[c] = HW'(HOLD_SAMPLES);
                end else if (hold_q[c] != '0) begin
                    hold_d[c] = hold_q[c] - HW'(1);
                end else begin
                    peak_d[c] = decayed[c];
                end

                // Flag follows the count before this sample's decrement so it stays lit
                // for CLIP_HOLD samples after the last clipped one.
                if (mag[c] >= CLIP_THRESH[W-2:0]) begin
                    clip_cnt_d[c] = CW'(CLIP_HOLD);
                    clip_d[c]     = 1'b1;
                end else begin
                    clip_d[c] = (clip_cnt_q[c] != '0);
                    if (clip_cnt_q[c] != '0)
                        clip_cnt_d[c] = clip_cnt_q[c] - CW'(1);
                end
            end

            for (int k = 0; k < SEGS; k++)
                bar_d[c][k] = (peak_d[c] >= ((W-1)'(1) << (BAR_BASE + k)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                peak_q[c]     <= '0;
                hold_q[c]     <= '0;
                clip_cnt_q[c] <= '0;
                bar_q[c]      <= '0;
                clip_q[c]     <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                peak_q[c]     <= peak_d[c];
                hold_q[c]     <= hold_d[c];
                clip_cnt_q[c] <= clip_cnt_d[c];
                bar_q[c]      <= bar_d[c];
                clip_q[c]     <= clip_d[c];
            end
        end
    end

    assign peak_left  = peak_q[0];
    assign peak_right = peak_q[1];
    assign bar_left   = bar_q[0];
    assign bar_right  = bar_q[1];
    assign clip_left  = clip_q[0];
    assign clip_right = clip_q[1];

endmodule
